udma_adc_ts_mch_reg_if: RTL and testbench

- Multi-channel register interface for the uDMA ADC timestamp channel; generalises the single-channel RX config interface to NB_CH independent RX channels.
- Each channel has programmable datasize and an internal saturating pending-sample counter.
- A per-channel threshold interrupt is driven from the pending counter.
- Sits between the peripheral config bus and NB_CH uDMA RX channel controllers.

---
 rtl/udma_adc_ts_mch_reg_if.sv | 192 +++++++++++++++++++
 tb/tb_udma_adc_ts_mch_reg_if.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/udma_adc_ts_mch_reg_if.sv
// Multi-channel register interface for the uDMA ADC timestamp channel.
// Channel c owns words 4c..4c+3 (SADDR, SIZE, CFG, PEND). THR sits at word 4*NB_CH and
// IRQ_STAT at word 4*NB_CH+1. Every other address reads 0 and ignores writes.
// Each channel keeps a saturating pending-sample counter. A PEND read returns the counter
// and clears it. irq_o[c] is a registered "counter >= shared threshold" flag.
// Optional feature: define UDMA_ADC_TS_OVF_EN to add a sticky per-channel overflow flag.
// The flag reads back in PEND bit 31.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   cfg_*_i / cfg_data_o         config bus (read data is combinational), cfg_ready_o = 1
//   cfg_rx_*_o                   per-channel RX config, channel c at slice c
//   cfg_rx_*_i                   per-channel RX status
//   ch_event_i                   one-cycle pulse per sample written
//   irq_o                        per-channel threshold interrupt
module udma_adc_ts_mch_reg_if #(
  parameter int unsigned NB_CH          = 2,
  parameter int unsigned L2_AWIDTH_NOAL = 12,
  parameter int unsigned TRANS_SIZE     = 16,
  parameter int unsigned CNT_W          = 14
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [31:0]                        cfg_data_i,
  input  logic [4:0]                         cfg_addr_i,
  input  logic                               cfg_valid_i,
  input  logic                               cfg_rwn_i,
  output logic [31:0]                        cfg_data_o,
  output logic                               cfg_ready_o,
  output logic [NB_CH*L2_AWIDTH_NOAL-1:0]    cfg_rx_startaddr_o,
  output logic [NB_CH*TRANS_SIZE-1:0]        cfg_rx_size_o,
  output logic [NB_CH*2-1:0]                 cfg_rx_datasize_o,
  output logic [NB_CH-1:0]                   cfg_rx_continuous_o,
  output logic [NB_CH-1:0]                   cfg_rx_en_o,
  output logic [NB_CH-1:0]                   cfg_rx_clr_o,
  input  logic [NB_CH-1:0]                   cfg_rx_en_i,
  input  logic [NB_CH-1:0]                   cfg_rx_pending_i,
  input  logic [NB_CH*L2_AWIDTH_NOAL-1:0]    cfg_rx_curr_addr_i,
  input  logic [NB_CH*TRANS_SIZE-1:0]        cfg_rx_bytes_left_i,
  input  logic [NB_CH-1:0]                   ch_event_i,
  output logic [NB_CH-1:0]                   irq_o
);

  localparam int unsigned ThrAddr = 4 * NB_CH;
  localparam int unsigned IrqAddr = 4 * NB_CH + 1;
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [L2_AWIDTH_NOAL-1:0] saddr_q [NB_CH];
  logic [L2_AWIDTH_NOAL-1:0] saddr_d [NB_CH];
  logic [TRANS_SIZE-1:0]     size_q  [NB_CH];
  logic [TRANS_SIZE-1:0]     size_d  [NB_CH];
  logic [1:0]                ds_q    [NB_CH];
  logic [1:0]                ds_d    [NB_CH];
  logic [CNT_W-1:0]          cnt_q   [NB_CH];
  logic [CNT_W-1:0]          cnt_d   [NB_CH];
  logic [NB_CH-1:0]          cont_q, cont_d, en_q, en_d, clr_q, clr_d, irq_q, irq_d;
  logic [CNT_W-1:0]          thr_q, thr_d;
`ifdef UDMA_ADC_TS_OVF_EN
  logic [NB_CH-1:0]          ovf_q, ovf_d;
`endif

  logic [2:0] ch_sel;
  logic [1:0] reg_sel;
  logic       ch_hit, wr, rd;
  logic       unused_data;

  assign ch_sel      = cfg_addr_i[4:2];
  assign reg_sel     = cfg_addr_i[1:0];
  assign ch_hit      = 32'(ch_sel) < NB_CH;
  assign wr          = cfg_valid_i & ~cfg_rwn_i;
  assign rd          = cfg_valid_i & cfg_rwn_i;
  assign cfg_ready_o = 1'b1;
  assign unused_data = ^cfg_data_i;

  // Next-state: register writes, pulses and pending counters.
  always_comb begin
    thr_d = thr_q;
    if (wr && 32'(cfg_addr_i) == ThrAddr) thr_d = cfg_data_i[CNT_W-1:0];
    for (int c = 0; c < NB_CH; c++) begin
      logic sel, pend_rd;
      sel       = ch_hit && (ch_sel == 3'(c));
      pend_rd   = rd && sel && (reg_sel == 2'd3);
      saddr_d[c] = saddr_q[c];
      size_d[c]  = size_q[c];
      ds_d[c]    = ds_q[c];
      cont_d[c]  = cont_q[c];
      en_d[c]    = 1'b0;
      clr_d[c]   = 1'b0;
      if (wr && sel) begin
        case (reg_sel)
          2'd0: saddr_d[c] = cfg_data_i[L2_AWIDTH_NOAL-1:0];
          2'd1: size_d[c]  = cfg_data_i[TRANS_SIZE-1:0];
          2'd2: begin
            cont_d[c] = cfg_data_i[0];
            ds_d[c]   = cfg_data_i[2:1];
            en_d[c]   = cfg_data_i[4];
            clr_d[c]  = cfg_data_i[5];
          end
          default: ;
        endcase
      end
      // A read that coincides with an event leaves that event counted.
      if (pend_rd) begin
        cnt_d[c] = ch_event_i[c] ? CNT_W'(1) : '0;
      end else if (ch_event_i[c] && cnt_q[c] != CntMax) begin
        cnt_d[c] = cnt_q[c] + CNT_W'(1);
      end else begin
        cnt_d[c] = cnt_q[c];
      end
`ifdef UDMA_ADC_TS_OVF_EN
      // Set wins over the read-clear so an overflow is never lost.
      ovf_d[c] = (ovf_q[c] & ~pend_rd) | (ch_event_i[c] & (cnt_q[c] == CntMax));
`endif
      irq_d[c] = (thr_q != '0) && (cnt_d[c] >= thr_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int c = 0; c < NB_CH; c++) begin
        saddr_q[c] <= '0;
        size_q[c]  <= '0;
        ds_q[c]    <= 2'b10;
        cnt_q[c]   <= '0;
      end
      cont_q <= '0;
      en_q   <= '0;
      clr_q  <= '0;
      irq_q  <= '0;
      thr_q  <= '0;
`ifdef UDMA_ADC_TS_OVF_EN
      ovf_q  <= '0;
`endif
    end else begin
      for (int c = 0; c < NB_CH; c++) begin
        saddr_q[c] <= saddr_d[c];
        size_q[c]  <= size_d[c];
        ds_q[c]    <= ds_d[c];
        cnt_q[c]   <= cnt_d[c];
      end
      cont_q <= cont_d;
      en_q   <= en_d;
      clr_q  <= clr_d;
      irq_q  <= irq_d;
      thr_q  <= thr_d;
`ifdef UDMA_ADC_TS_OVF_EN
      ovf_q  <= ovf_d;
`endif
    end
  end

  // Combinational read mux, zero unless a valid read hits a mapped register.
  always_comb begin
    cfg_data_o = '0;
    if (rd) begin
      if (ch_hit) begin
        for (int c = 0; c < NB_CH; c++) begin
          if (ch_sel == 3'(c)) begin
            case (reg_sel)
              2'd0: cfg_data_o[L2_AWIDTH_NOAL-1:0] =
                      cfg_rx_curr_addr_i[c*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL];
              2'd1: cfg_data_o[TRANS_SIZE-1:0] = cfg_rx_bytes_left_i[c*TRANS_SIZE +: TRANS_SIZE];
              2'd2: cfg_data_o[5:0] = {cfg_rx_pending_i[c], cfg_rx_en_i[c], 1'b0, ds_q[c],
                                       cont_q[c]};
              default: begin
                cfg_data_o[CNT_W-1:0] = cnt_q[c];
`ifdef UDMA_ADC_TS_OVF_EN
                cfg_data_o[31] = ovf_q[c];
`endif
              end
            endcase
          end
        end
      end else if (32'(cfg_addr_i) == ThrAddr) begin
        cfg_data_o[CNT_W-1:0] = thr_q;
      end else if (32'(cfg_addr_i) == IrqAddr) begin
        cfg_data_o[NB_CH-1:0] = irq_q;
      end
    end
  end

  for (genvar g = 0; g < NB_CH; g++) begin : g_out
    assign cfg_rx_startaddr_o[g*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL] = saddr_q[g];
    assign cfg_rx_size_o[g*TRANS_SIZE +: TRANS_SIZE]              = size_q[g];
    assign cfg_rx_datasize_o[g*2 +: 2]                            = ds_q[g];
  end

  assign cfg_rx_continuous_o = cont_q;
  assign cfg_rx_en_o         = en_q;
  assign cfg_rx_clr_o        = clr_q;
  assign irq_o               = irq_q;

endmodule

// File: tb/tb_udma_adc_ts_mch_reg_if.sv
module tb_udma_adc_ts_mch_reg_if;

  localparam int NB_CH = 2;
  localparam int AW    = 12;
  localparam int TS    = 16;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;
  localparam int THR_A = 4 * NB_CH;
  localparam int IRQ_A = 4 * NB_CH + 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [31:0]           cfg_data_i;
  logic [4:0]            cfg_addr_i;
  logic                  cfg_valid_i;
  logic                  cfg_rwn_i;
  logic [31:0]           cfg_data_o;
  logic                  cfg_ready_o;
  logic [NB_CH*AW-1:0]   startaddr_o;
  logic [NB_CH*TS-1:0]   size_o;
  logic [NB_CH*2-1:0]    datasize_o;
  logic [NB_CH-1:0]      cont_o, en_o, clr_o, irq_o;
  logic [NB_CH-1:0]      en_i, pend_i, ev_i;
  logic [NB_CH*AW-1:0]   curr_addr_i;
  logic [NB_CH*TS-1:0]   bytes_left_i;

  always #5 clk = ~clk;

  udma_adc_ts_mch_reg_if #(
    .NB_CH(NB_CH), .L2_AWIDTH_NOAL(AW), .TRANS_SIZE(TS), .CNT_W(CW)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .cfg_data_i          (cfg_data_i),
    .cfg_addr_i          (cfg_addr_i),
    .cfg_valid_i         (cfg_valid_i),
    .cfg_rwn_i           (cfg_rwn_i),
    .cfg_data_o          (cfg_data_o),
    .cfg_ready_o         (cfg_ready_o),
    .cfg_rx_startaddr_o  (startaddr_o),
    .cfg_rx_size_o       (size_o),
    .cfg_rx_datasize_o   (datasize_o),
    .cfg_rx_continuous_o (cont_o),
    .cfg_rx_en_o         (en_o),
    .cfg_rx_clr_o        (clr_o),
    .cfg_rx_en_i         (en_i),
    .cfg_rx_pending_i    (pend_i),
    .cfg_rx_curr_addr_i  (curr_addr_i),
    .cfg_rx_bytes_left_i (bytes_left_i),
    .ch_event_i          (ev_i),
    .irq_o               (irq_o)
  );

  // Reference model state
  logic [AW-1:0]    m_saddr [NB_CH];
  logic [TS-1:0]    m_size  [NB_CH];
  logic [1:0]       m_ds    [NB_CH];
  logic [NB_CH-1:0] m_cont, m_en, m_clr, m_ovf, m_irq;
  int               m_cnt   [NB_CH];
  int               m_thr;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] last_rd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NB_CH; c++) begin
      m_saddr[c] = '0;
      m_size[c]  = '0;
      m_ds[c]    = 2'b10;
      m_cnt[c]   = 0;
    end
    m_cont = '0; m_en = '0; m_clr = '0; m_ovf = '0; m_irq = '0; m_thr = 0;
  endtask

  function automatic logic [31:0] exp_rd(input int a);
    logic [31:0] r;
    int c;
    r = '0;
    c = a / 4;
    if (a < 4 * NB_CH) begin
      case (a % 4)
        0: r = 32'(curr_addr_i[c*AW +: AW]);
        1: r = 32'(bytes_left_i[c*TS +: TS]);
        2: r = {26'h0, pend_i[c], en_i[c], 1'b0, m_ds[c], m_cont[c]};
        default: begin
          r = 32'(m_cnt[c]);
`ifdef UDMA_ADC_TS_OVF_EN
          r[31] = m_ovf[c];
`endif
        end
      endcase
    end else if (a == THR_A) begin
      r = 32'(m_thr);
    end else if (a == IRQ_A) begin
      r = 32'(m_irq);
    end
    return r;
  endfunction

  // Applies the register-map rules for one clock edge using the inputs held at that edge.
  task automatic model_edge();
    int   a;
    logic wr, rd, pr, ev;
    a  = int'(cfg_addr_i);
    wr = cfg_valid_i && !cfg_rwn_i;
    rd = cfg_valid_i && cfg_rwn_i;
    if (rst) begin
      model_reset();
      return;
    end
    for (int c = 0; c < NB_CH; c++) begin
      pr = rd && (a == 4 * c + 3);
      ev = ev_i[c];
      m_ovf[c] = (pr ? 1'b0 : m_ovf[c]) | (ev && m_cnt[c] == CMAX);
      if (pr) m_cnt[c] = ev ? 1 : 0;
      else if (ev && m_cnt[c] < CMAX) m_cnt[c] = m_cnt[c] + 1;
      m_irq[c] = (m_thr != 0) && (m_cnt[c] >= m_thr);
      m_en[c]  = 1'b0;
      m_clr[c] = 1'b0;
    end
    if (wr) begin
      if (a < 4 * NB_CH) begin
        case (a % 4)
          0: m_saddr[a/4] = cfg_data_i[AW-1:0];
          1: m_size[a/4]  = cfg_data_i[TS-1:0];
          2: begin
            m_cont[a/4] = cfg_data_i[0];
            m_ds[a/4]   = cfg_data_i[2:1];
            m_en[a/4]   = cfg_data_i[4];
            m_clr[a/4]  = cfg_data_i[5];
          end
          default: ;
        endcase
      end else if (a == THR_A) begin
        m_thr = int'(cfg_data_i[CW-1:0]);
      end
    end
  endtask

  // One clock: check comb read data, advance model at the edge, then check registered outputs.
  task automatic cycle();
    logic [NB_CH*AW-1:0] e_sa;
    logic [NB_CH*TS-1:0] e_sz;
    logic [NB_CH*2-1:0]  e_ds;
    #2;
    last_rd = cfg_data_o;
    chk("rdata", cfg_data_o, (cfg_valid_i && cfg_rwn_i) ? exp_rd(int'(cfg_addr_i)) : 32'h0);
    chk("ready", cfg_ready_o, 1);
    @(posedge clk);
    model_edge();
    #1;
    for (int c = 0; c < NB_CH; c++) begin
      e_sa[c*AW +: AW] = m_saddr[c];
      e_sz[c*TS +: TS] = m_size[c];
      e_ds[c*2 +: 2]   = m_ds[c];
    end
    chk("startaddr", startaddr_o, e_sa);
    chk("size", size_o, e_sz);
    chk("datasize", datasize_o, e_ds);
    chk("continuous", cont_o, m_cont);
    chk("en_pulse", en_o, m_en);
    chk("clr_pulse", clr_o, m_clr);
    chk("irq", irq_o, m_irq);
  endtask

  task automatic bus(input logic v, input logic r, input int a, input logic [31:0] d,
                     input logic [NB_CH-1:0] ev);
    cfg_valid_i = v;
    cfg_rwn_i   = r;
    cfg_addr_i  = 5'(a);
    cfg_data_i  = d;
    ev_i        = ev;
    cycle();
  endtask

  initial begin
    int a;
    logic [31:0] d;
    model_reset();
    rst = 1'b1; en_i = '0; pend_i = '0;
    curr_addr_i  = NB_CH*AW'($urandom);
    bytes_left_i = NB_CH*TS'($urandom);
    bus(0, 0, 0, 0, '0);
    bus(0, 0, 0, 0, '0);
    rst = 1'b0;

    // Reset values read back
    for (int i = 0; i < 32; i++) bus(1, 1, i, 0, '0);
    bus(1, 1, 2, 0, '0);      chk("cfg0_rst", last_rd, 32'h4);
    bus(1, 1, 1, 0, '0);      chk("size0_rd", last_rd, 32'(bytes_left_i[TS-1:0]));
    bus(1, 1, THR_A, 0, '0);  chk("thr_rst", last_rd, 0);
    chk("irq_rst", irq_o, 0);

    // ch1 CFG write: en/clr pulse for one cycle, ch0 untouched
    bus(1, 0, 6, 32'h31, '0);
    chk("en1", en_o, 2'b10);
    chk("clr1", clr_o, 2'b10);
    chk("cont1", cont_o, 2'b10);
    chk("ds_after", datasize_o, 4'b0010);
    bus(0, 0, 0, 0, '0);
    chk("en1_drop", en_o, 0);
    chk("clr1_drop", clr_o, 0);

    // Five events then PEND read
    repeat (5) bus(0, 0, 0, 0, 2'b01);
    bus(1, 1, 3, 0, '0);      chk("pend5", last_rd, 5);
    bus(1, 1, 3, 0, '0);      chk("pend0", last_rd, 0);

    // Threshold interrupt
    bus(1, 0, THR_A, 3, '0);
    bus(0, 0, 0, 0, 2'b01);
    bus(0, 0, 0, 0, 2'b01);   chk("irq_below", irq_o, 0);
    bus(0, 0, 0, 0, 2'b01);   chk("irq_rise", irq_o, 2'b01);
    bus(1, 1, IRQ_A, 0, '0);  chk("irq_stat", last_rd, 1);
    bus(1, 1, 3, 0, '0);      chk("pend3", last_rd, 3);
    chk("irq_clr", irq_o, 0);

    // Read coincident with event at count 7
    repeat (7) bus(0, 0, 0, 0, 2'b01);
    bus(1, 1, 3, 0, 2'b01);   chk("pend7", last_rd, 7);
    bus(1, 1, 3, 0, '0);      chk("pend_after", last_rd, 1);

    // Saturation (and overflow flag when built in)
    bus(1, 0, THR_A, 0, '0);
    repeat (CMAX + 1) bus(0, 0, 0, 0, 2'b01);
`ifdef UDMA_ADC_TS_OVF_EN
    bus(1, 1, 3, 0, '0);      chk("pend_sat_ovf", last_rd, 32'h8000_0000 | CMAX);
`else
    bus(1, 1, 3, 0, '0);      chk("pend_sat", last_rd, CMAX);
`endif
    bus(1, 1, 3, 0, '0);      chk("pend_sat_clr", last_rd, 0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      en_i         = NB_CH'($urandom);
      pend_i       = NB_CH'($urandom);
      curr_addr_i  = NB_CH*AW'($urandom);
      bytes_left_i = NB_CH*TS'($urandom);
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, IRQ_A);
      d = (a == THR_A) ? $urandom_range(0, 10) : $urandom;
      bus($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, a, d,
          NB_CH'($urandom) & NB_CH'($urandom));
    end

    // Reset mid-operation drops a coincident enable pulse
    en_i = '0; pend_i = '0;
    rst = 1'b1;
    bus(1, 0, 2, 32'h31, 2'b11);
    chk("rst_en", en_o, 0);
    chk("rst_irq", irq_o, 0);
    rst = 1'b0;
    bus(1, 1, 2, 0, '0);      chk("cfg0_after_rst", last_rd, 32'h4);
    bus(1, 1, 3, 0, '0);      chk("pend_after_rst", last_rd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
